// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Constants shared between the core ALU and the blocks that borrow it.
//   ALU opcodes (4 bit) and the state type of the multiply sequencer.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// ----------------------------------------------------------------------------
// alu_mul_sequencer
//   Computes the low XLEN bits of op_a*op_b by shift-and-add, using the shared
//   core ALU for every addition. One ALU add per granted cycle; the run ends
//   as soon as no set multiplier bits remain.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start_valid/start_ready  operand handshake (op_a multiplicand, op_b multiplier)
//   flush                    synchronous abort back to idle
//   alu_req/alu_gnt          borrow request / grant for the shared ALU
//   alu_src1/alu_src2        accumulator / shifted multiplicand to the ALU
//   alu_code                 ALU opcode, ADD while requesting
//   alu_result               ALU sum back from the core
//   res_valid/res_ready      product handshake, res_data = product
// ----------------------------------------------------------------------------
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [3:0]      alu_code,
    input  logic [XLEN-1:0] alu_result,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data
);

    mul_state_t      state_reg, state_next;
    logic [XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0] mcand_reg, mcand_next;
    logic [XLEN-1:0] mplier_reg, mplier_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;

        if (flush) begin
            // Abort wins over everything else, including a coincident start.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid) begin
                        acc_next    = '0;
                        mcand_next  = op_a;
                        mplier_next = op_b;
                        cnt_next    = '0;
                        // A zero multiplier needs no additions at all.
                        state_next  = (op_b != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    // Without a grant the ALU result belongs to someone else,
                    // so every register simply holds.
                    if (alu_gnt) begin
                        if (mplier_reg[0]) begin
                            acc_next = alu_result;
                        end
                        mcand_next  = mcand_reg << 1;
                        mplier_next = mplier_reg >> 1;
                        cnt_next    = cnt_reg + 1'b1;
                        if (((mplier_reg >> 1) == '0) || (cnt_reg == CNT_LAST)) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

    // All outputs are decoded from registers only, so the arbiter's
    // combinational grant cannot loop back through this block.
    assign start_ready = (state_reg == IDLE);
    assign alu_req     = (state_reg == RUN);
    assign alu_code    = alu_req ? ALU_ADD : 4'b0000;
    assign alu_src1    = acc_reg;
    assign alu_src2    = mcand_reg;
    assign res_valid   = (state_reg == DONE);
    assign res_data    = res_valid ? acc_reg : '0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        flush = 1'b0;
    logic        alu_req;
    logic        alu_gnt = 1'b0;
    logic [63:0] alu_src1;
    logic [63:0] alu_src2;
    logic [3:0]  alu_code;
    logic [63:0] alu_result;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;

    int errors = 0;
    int checks = 0;
    int pat [5] = '{1, 0, 0, 1, 1};

    always #5 clk = ~clk;

    // Stand-in for the core ALU.
    always_comb begin
        case (alu_code)
            ALU_AND: alu_result = alu_src1 & alu_src2;
            ALU_OR:  alu_result = alu_src1 | alu_src2;
            ALU_ADD: alu_result = alu_src1 + alu_src2;
            ALU_SUB: alu_result = alu_src1 - alu_src2;
            default: alu_result = '0;
        endcase
    end

    alu_mul_sequencer #(.XLEN(64), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_code(alu_code),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // Reference: number of shift-add steps is the bit length of the multiplier.
    function automatic int ref_steps(input logic [63:0] b);
        for (int i = 63; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation up to the point where the product is presented
    // (no result handshake). mode: 0 grant always, 1 fixed pattern, 2 random.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input int mode,
                         output logic [63:0] prod, output int lat, output int steps,
                         output int runc, output bit stable, output bit tmo);
        int pidx;
        bit g;
        bit stalled;
        logic [63:0] s1, s2;
        pidx = 0; stable = 1'b1; tmo = 1'b0; lat = 0; steps = 0; runc = 0;
        s1 = '0; s2 = '0;
        op_a = a; op_b = b; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 1000) begin
            g = 1'b0;
            stalled = 1'b0;
            if (alu_req) begin
                runc++;
                case (mode)
                    0: g = 1'b1;
                    1: g = (pidx < 5) ? (pat[pidx] != 0) : 1'b1;
                    default: g = ($urandom_range(0, 1) == 1);
                endcase
                pidx++;
                if (g) steps++;
                else begin
                    stalled = 1'b1;
                    s1 = alu_src1;
                    s2 = alu_src2;
                end
            end
            alu_gnt = g;
            tick();
            lat++;
            if (stalled && (alu_src1 !== s1 || alu_src2 !== s2)) stable = 1'b0;
        end
        alu_gnt = 1'b0;
        tmo = !res_valid;
        prod = res_data;
        $display("op a=%h b=%h prod=%h lat=%0d steps=%0d run=%0d", a, b, prod, lat, steps, runc);
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (alu_req !== 1'b0 || res_valid !== 1'b0 || res_data !== 64'd0 || alu_code !== 4'd0 ||
            alu_src1 !== 64'd0 || alu_src2 !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs req=%b valid=%b data=%h code=%h src1=%h src2=%h required all zero",
                     alu_req, res_valid, res_data, alu_code, alu_src1, alu_src2);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b required=1", start_ready);
        end
    endtask

    task automatic test_basic();
        logic [63:0] p; int lat, st, rc; bit stb, tmo;
        do_op(64'd3, 64'd5, 0, p, lat, st, rc, stb, tmo);
        checks++;
        if (tmo || p !== 64'd15) begin
            errors++; $display("FAIL basic_3x5 got=%h tmo=%b required=%h", p, tmo, 64'd15);
        end
        checks++;
        if (rc !== 3 || lat !== 4) begin
            errors++; $display("FAIL basic_latency run=%0d lat=%0d required run=3 lat=4", rc, lat);
        end
        accept_result();
    endtask

    task automatic test_zero();
        logic [63:0] p; int lat, st, rc; bit stb, tmo;
        do_op(64'd123, 64'd0, 0, p, lat, st, rc, stb, tmo);
        checks++;
        if (tmo || p !== 64'd0 || rc !== 0 || lat !== 1) begin
            errors++;
            $display("FAIL zero_mult got=%h run=%0d lat=%0d required data=0 run=0 lat=1", p, rc, lat);
        end
        accept_result();
    endtask

    task automatic test_extremes();
        logic [63:0] p; int lat, st, rc; bit stb, tmo;
        do_op({64{1'b1}}, {64{1'b1}}, 0, p, lat, st, rc, stb, tmo);
        checks++;
        if (tmo || p !== 64'd1 || st !== 64) begin
            errors++; $display("FAIL all_ones got=%h steps=%0d required=1 steps=64", p, st);
        end
        accept_result();
        do_op(64'h8000_0000_0000_0000, 64'd2, 0, p, lat, st, rc, stb, tmo);
        checks++;
        if (tmo || p !== 64'd0 || st !== 2) begin
            errors++; $display("FAIL wrap_2p63x2 got=%h steps=%0d required=0 steps=2", p, st);
        end
        accept_result();
    endtask

    task automatic test_stall();
        logic [63:0] p; int lat, st, rc; bit stb, tmo;
        do_op(64'd7, 64'd6, 1, p, lat, st, rc, stb, tmo);
        checks++;
        if (tmo || p !== 64'd42 || st !== 3 || rc !== 5) begin
            errors++;
            $display("FAIL stall_7x6 got=%h steps=%0d run=%0d required=42 steps=3 run=5", p, st, rc);
        end
        checks++;
        if (!stb) begin
            errors++; $display("FAIL stall_src_stable got=unstable required=stable");
        end
        accept_result();
    endtask

    task automatic test_back_to_back();
        logic [63:0] p; int lat, st, rc; bit stb, tmo;
        bit held;
        do_op(64'd11, 64'd13, 0, p, lat, st, rc, stb, tmo);
        held = 1'b1;
        start_valid = 1'b1; op_a = 64'd99; op_b = 64'd99;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== 64'd143 || start_ready !== 1'b0) held = 1'b0;
        end
        start_valid = 1'b0;
        checks++;
        if (tmo || !held) begin
            errors++;
            $display("FAIL done_hold valid=%b data=%h ready=%b required valid=1 data=%h ready=0",
                     res_valid, res_data, start_ready, 64'd143);
        end
        accept_result();
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake ready=%b valid=%b required ready=1 valid=0", start_ready, res_valid);
        end
        do_op(64'd20, 64'd21, 0, p, lat, st, rc, stb, tmo);
        checks++;
        if (tmo || p !== 64'd420) begin
            errors++; $display("FAIL back_to_back got=%h required=%h", p, 64'd420);
        end
        accept_result();
    endtask

    task automatic test_random();
        logic [63:0] a, b, p, mask, expv; int lat, st, rc, w; bit stb, tmo;
        for (int n = 0; n < 16; n++) begin
            a = {$urandom, $urandom};
            w = $urandom_range(0, 64);
            mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
            b = {$urandom, $urandom} & mask;
            expv = a * b;
            do_op(a, b, 2, p, lat, st, rc, stb, tmo);
            checks++;
            if (tmo || p !== expv || st !== ref_steps(b) || lat !== rc + 1 || !stb) begin
                errors++;
                $display("FAIL random_%0d got=%h steps=%0d lat=%0d run=%0d required=%h steps=%0d lat=%0d",
                         n, p, st, lat, rc, expv, ref_steps(b), rc + 1);
            end
            accept_result();
        end
    endtask

    task automatic test_flush_reset();
        logic [63:0] p; int lat, st, rc; bit stb, tmo;
        bit quiet;
        op_a = 64'd5; op_b = 64'hFF; start_valid = 1'b1;
        tick();
        start_valid = 1'b0; alu_gnt = 1'b1;
        tick(); tick();
        flush = 1'b1; start_valid = 1'b1;
        tick();
        flush = 1'b0; start_valid = 1'b0; alu_gnt = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || alu_req !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle ready=%b req=%b valid=%b required 1 0 0", start_ready, alu_req, res_valid);
        end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid !== 1'b0 || alu_req !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL flush_quiet got=activity required=none");
        end
        // Reset in the middle of a run.
        op_a = 64'd5; op_b = 64'hFF; start_valid = 1'b1;
        tick();
        start_valid = 1'b0; alu_gnt = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_req !== 1'b0 || res_valid !== 1'b0 || alu_src1 !== 64'd0 || alu_src2 !== 64'd0) begin
            errors++;
            $display("FAIL reset_midrun req=%b valid=%b src1=%h src2=%h required all zero",
                     alu_req, res_valid, alu_src1, alu_src2);
        end
        alu_gnt = 1'b0;
        tick();
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid !== 1'b0 || start_ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL reset_quiet got=activity required=idle");
        end
        do_op(64'd9, 64'd9, 0, p, lat, st, rc, stb, tmo);
        checks++;
        if (tmo || p !== 64'd81) begin
            errors++; $display("FAIL after_abort_9x9 got=%h required=%h", p, 64'd81);
        end
        accept_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_extremes();
        test_stall();
        test_back_to_back();
        test_random();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
